// File: rtl/sample_tick_gen.sv
// Runtime-programmable sample-enable generator: one-cycle o_tick every (div+1) clocks,
// continuous or counted-burst, with divider changes taking effect only at period boundaries.
module sample_tick_gen #(
   parameter int DIV_W   = 24,
   parameter int CNT_W   = 16,
   parameter int RST_DIV = 49
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [DIV_W-1:0] i_div,
   input  logic             i_div_vld,
   input  logic             i_burst_mode,
   input  logic [CNT_W-1:0] i_burst_len,
   input  logic             i_start,
   input  logic             i_stop,
   output logic             o_tick,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_tick_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [DIV_W-1:0] RST_DIV_V = DIV_W'(RST_DIV);

   logic [0:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] active_div_q, active_div_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             pend_q, pend_d;
   logic             tick_q, tick_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
   logic             mode_q, mode_d;
   logic [CNT_W-1:0] len_q, len_d;

   logic wrap;
   logic burst_end;

   assign wrap      = (cnt_q == active_div_q);
   // The final burst tick is visible this cycle; leave RUN at the next edge.
   assign burst_end = mode_q && tick_q && (tick_cnt_q == len_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      active_div_d = active_div_q;
      pend_div_d   = pend_div_q;
      pend_d       = pend_q;
      tick_d       = 1'b0;
      done_d       = 1'b0;
      tick_cnt_d   = tick_cnt_q;
      mode_d       = mode_q;
      len_d        = len_q;

      case (state_q)
         ST_IDLE: begin
            if (i_div_vld) begin
               active_div_d = i_div;
               pend_d       = 1'b0;
            end
            if (i_start && !i_stop) begin
               cnt_d      = '0;
               tick_cnt_d = '0;
               if (!i_div_vld && pend_q) begin
                  active_div_d = pend_div_q;
                  pend_d       = 1'b0;
               end
               if (i_burst_mode && (i_burst_len == '0)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  mode_d  = i_burst_mode;
                  len_d   = i_burst_len;
               end
            end
         end
         default: begin
            if (i_stop) begin
               state_d = ST_IDLE;
            end else if (burst_end) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (wrap) begin
               cnt_d  = '0;
               tick_d = 1'b1;
               if (tick_cnt_q != '1) tick_cnt_d = tick_cnt_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end

            // A load on the wrap cycle goes straight into the next period.
            if (wrap && i_div_vld) begin
               active_div_d = i_div;
               pend_d       = 1'b0;
            end else if (i_div_vld) begin
               pend_div_d = i_div;
               pend_d     = 1'b1;
            end else if (wrap && pend_q) begin
               active_div_d = pend_div_q;
               pend_d       = 1'b0;
            end
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         active_div_q <= RST_DIV_V;
         pend_div_q   <= '0;
         pend_q       <= 1'b0;
         tick_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tick_cnt_q   <= '0;
         mode_q       <= 1'b0;
         len_q        <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         active_div_q <= active_div_d;
         pend_div_q   <= pend_div_d;
         pend_q       <= pend_d;
         tick_q       <= tick_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         tick_cnt_q   <= tick_cnt_d;
         mode_q       <= mode_d;
         len_q        <= len_d;
      end
   end

   assign o_tick     = tick_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_tick_cnt = tick_cnt_q;

endmodule
